// File: rtl/stage_writeback.sv
// Writeback stage: commits modify-stage results to the data RAM or the output port,
// services input-port reads, and closes the drdy/ack handshake with the modify stage.
module stage_writeback #(
    parameter int D_WIDTH    = 8,
    parameter int C_WIDTH    = 16,
    parameter int OPCODE_MSB = 3,
    parameter int OP_INC     = 0,
    parameter int OP_DEC     = 1,
    parameter int OP_IN      = 2,
    parameter int OP_OUT     = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OPCODE_MSB:0]  operation_in,
    input  logic [D_WIDTH-1:0]   a_in,
    input  logic                 drdy_in,
    output logic                 ack,
    output logic [D_WIDTH-1:0]   d_wdata,
    output logic                 d_we,
    output logic [D_WIDTH-1:0]   out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic [D_WIDTH-1:0]   in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 busy,
    output logic [C_WIDTH-1:0]   retired
);

    // state    | meaning
    // IDLE     | waiting for drdy_in from the modify stage
    // OUT_WAIT | out_data presented, waiting for out_ready
    // IN_WAIT  | in_ready raised, waiting for in_valid
    // DONE     | op committed, ack held until drdy_in drops
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OUT_WAIT = 2'd1,
        IN_WAIT  = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 ack_q, ack_d;
    logic                 d_we_q, d_we_d;
    logic [D_WIDTH-1:0]   d_wdata_q, d_wdata_d;
    logic [D_WIDTH-1:0]   out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_ready_q, in_ready_d;
    logic                 busy_q, busy_d;
    logic [C_WIDTH-1:0]   retired_q, retired_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            ack_q       <= 1'b0;
            d_we_q      <= 1'b0;
            d_wdata_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            d_we_q      <= d_we_d;
            d_wdata_q   <= d_wdata_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            retired_q   <= retired_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ack_d       = ack_q;
        d_we_d      = 1'b0;
        d_wdata_d   = d_wdata_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        retired_d   = retired_q;

        unique case (state_q)
            IDLE: begin
                if (drdy_in) begin
                    if (operation_in[OP_INC] || operation_in[OP_DEC]) begin
                        d_wdata_d = a_in;
                        d_we_d    = 1'b1;
                        ack_d     = 1'b1;
                        retired_d = retired_q + C_WIDTH'(1);
                        state_d   = DONE;
                    end else if (operation_in[OP_OUT]) begin
                        out_data_d  = a_in;
                        out_valid_d = 1'b1;
                        state_d     = OUT_WAIT;
                    end else if (operation_in[OP_IN]) begin
                        in_ready_d = 1'b1;
                        state_d    = IN_WAIT;
                    end else begin
                        // Unrecognised opcodes retire without touching RAM or ports.
                        ack_d     = 1'b1;
                        retired_d = retired_q + C_WIDTH'(1);
                        state_d   = DONE;
                    end
                end
            end
            OUT_WAIT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    ack_d       = 1'b1;
                    retired_d   = retired_q + C_WIDTH'(1);
                    state_d     = DONE;
                end
            end
            IN_WAIT: begin
                if (in_ready_q && in_valid) begin
                    d_wdata_d  = in_data;
                    d_we_d     = 1'b1;
                    in_ready_d = 1'b0;
                    ack_d      = 1'b1;
                    retired_d  = retired_q + C_WIDTH'(1);
                    state_d    = DONE;
                end
            end
            DONE: begin
                // drdy_in is only watched for its fall here, so a held request commits once.
                if (!drdy_in) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign ack       = ack_q;
    assign d_we      = d_we_q;
    assign d_wdata   = d_wdata_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign retired   = retired_q;

endmodule

// File: doc/stage_writeback.md
Name: stage_writeback

Overview:
- Final stage of the data pipeline. It sits directly downstream of the modify stage and consumes its registered operation, data word and drdy.
- Commits the result: INC/DEC values go to the data RAM write port, OUT values go to the output port, and IN takes a byte from the input port and writes it to the data RAM.
- Closes a four-phase drdy/ack handshake with the modify stage. The modify stage registers ack and forwards it upstream.

Parameters:
- D_WIDTH, 8, width of data cells and I/O bytes.
- C_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- operation_in  input  OPCODE_MSB+1  one-hot-ish opcode from the modify stage; bit indices are OP_INC, OP_DEC, OP_IN, OP_OUT from the shared constants header.
- a_in  input  D_WIDTH  result word from the modify stage.
- drdy_in  input  1  request from the modify stage; a level, held until ack is seen.
- ack  output  1  acknowledge to the modify stage.
- d_wdata  output  D_WIDTH  data RAM write data.
- d_we  output  1  data RAM write enable, one-cycle pulse. The address is supplied by the pointer stage.
- out_data  output  D_WIDTH  output port byte.
- out_valid  output  1  output byte valid.
- out_ready  input  1  output consumer ready.
- in_data  input  D_WIDTH  input port byte.
- in_valid  input  1  input byte valid.
- in_ready  output  1  block waiting for an input byte.
- busy  output  1  high in any state other than IDLE.
- retired  output  C_WIDTH  count of completed instructions.

Behaviour:
- All outputs are registered.
- Reset (reset==0 at a clock edge):
  - state goes to IDLE.
  - ack, d_we, out_valid, in_ready and busy go to 0.
  - d_wdata, out_data and retired go to 0.
  - Reset overrides everything, including mid-transaction. Any pending out_valid or in_ready is dropped with no write and no ack.
- States: IDLE, OUT_WAIT, IN_WAIT, DONE.
- IDLE with drdy_in==1: decode operation_in. Priority is INC > DEC > OUT > IN > other.
  - INC or DEC: d_wdata<=a_in, d_we<=1, ack<=1, retired+=1, go to DONE.
  - OUT: out_data<=a_in, out_valid<=1, go to OUT_WAIT.
  - IN: in_ready<=1, go to IN_WAIT.
  - Any other opcode, including 0: ack<=1, retired+=1, no write, go to DONE.
- IDLE with drdy_in==0: hold; no outputs change.
- d_we is high for exactly one cycle per write, then returns to 0 the next cycle.
- OUT_WAIT:
  - Transfer occurs on a cycle with out_valid==1 && out_ready==1.
  - Next cycle: out_valid<=0, ack<=1, retired+=1, go to DONE.
  - out_data is stable while out_valid==1.
  - out_ready high on the cycle out_valid rises counts as a transfer on that edge.
- IN_WAIT:
  - Transfer occurs on a cycle with in_valid==1 && in_ready==1.
  - Next cycle: d_wdata<=in_data (sampled on the transfer edge), d_we<=1, in_ready<=0, ack<=1, retired+=1, go to DONE.
  - in_valid while not in IN_WAIT is ignored.
- DONE:
  - ack held at 1 until drdy_in==0 is sampled.
  - Then ack<=0, go to IDLE.
  - A new request is accepted no earlier than the cycle after ack falls.
  - drdy_in is not re-sampled in DONE, so one request commits exactly once.
- Latency from drdy_in sampled high to ack high:
  - INC/DEC/other: 1 cycle.
  - OUT: 2 cycles minimum (ready already high).
  - IN: 2 cycles minimum (valid already high).
- retired wraps from 2^C_WIDTH-1 to 0.
- busy = (state != IDLE), registered alongside state.

Test Plan:
- Reset, then INC commit: reset=0 for 2 cycles → all outputs 0. Then reset=1, drdy_in=1, OP_INC, a_in=8'h05 → next cycle d_we=1, d_wdata=8'h05, ack=1, retired=1. Following cycle d_we=0, ack stays 1. Drop drdy_in → ack=0 one cycle later, busy=0.
- OUT with stalled consumer: OP_OUT, a_in=8'h41, out_ready=0 for 5 cycles → out_valid=1, out_data=8'h41 held, ack=0, d_we never asserted. Raise out_ready → next cycle out_valid=0, ack=1, retired increments by 1.
- IN: OP_IN, in_valid=0 for 3 cycles → in_ready=1, no write. Then in_valid=1, in_data=8'h7A → next cycle d_we=1, d_wdata=8'h7A, in_ready=0, ack=1.
- Handshake hold: keep drdy_in=1 for 10 cycles after ack on a DEC (a_in=8'hFF) → exactly one d_we pulse, retired +1 only, ack high throughout. Drop drdy_in → ack low, state IDLE.
- Reset mid-OUT: in OUT_WAIT with out_valid=1, assert reset=0 → next edge out_valid=0, ack=0, busy=0, retired=0. No ack is ever issued for the aborted op.
- Wrap and no-op: preload retired to 16'hFFFF via 65535 no-op requests (operation_in=0) → the next no-op gives retired=16'h0000, ack pulses, d_we stays 0.
